imem_loader: RTL and testbench
==============================

# imem_loader

Instruction-memory loader and program store sitting directly upstream of the `cpu` core. It receives a program as a byte stream over a valid/ready interface and writes it into an internal instruction RAM. It then serves `inst` combinationally for the core's `pc`. While loading, it holds the core in reset and frozen; once the final instruction word is written, it releases the core.

## Interface
- `IMSB`, 15, instruction MSB; instruction width is IMSB+1, fixed at 16 for the byte protocol
- `PMSB`, 7, program counter MSB; RAM depth D = 2^(PMSB+1) words
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset; asynchronous, active-high
- `in_valid`  in  1  byte on `in_data` is offered
- `in_data`  in  8  program byte
- `in_ready`  out  1  loader accepts a byte this cycle; a transfer occurs when `in_valid && in_ready` at the rising edge
- `reload`  in  1  single-cycle or level request to discard the current program and restart loading
- `pc`  in  PMSB+1  program counter from the core
- `inst`  out  IMSB+1  instruction for the core
- `run`  out  1  registered; drives the core's `setn`
- `core_rstn`  out  1  registered; drives the core's `rstn`

## Operation
- Stream format:
  - Header: 16-bit word count N, low byte first.
  - Body: N instruction words, each sent low byte first.
- States: HDR_LO, HDR_HI, INS_LO, INS_HI, RUN.
- HDR_LO --byte--> HDR_HI. The byte is latched as N[7:0].
- HDR_HI --byte--> INS_LO, with N[15:8] latched. If the completed N == 0, the transition goes to RUN instead.
- INS_LO --byte--> INS_HI. The byte is latched as `lo`.
- INS_HI --byte-->
  - If word index w < D, write mem[w] <= {byte, lo}.
  - Increment w (16-bit).
  - If the new w == N, go to RUN; otherwise go to INS_LO.
- Words with w ≥ D are accepted and discarded; no address wrap ever occurs.
- `loaded` register (width PMSB+2) equals min(w, D). It is cleared on entry to HDR_LO.
- RUN: `in_ready` = 0. Stay in RUN until `reload` is asserted.
- `reload` in any state:
  - Next state is HDR_LO.
  - w and `loaded` are cleared.
  - `run` and `core_rstn` are forced to 0.
  - RAM contents are not cleared.
- `in_ready` = (state != RUN) && !`reload` && !`rst` (combinational). A byte presented together with `reload` is not accepted.
- `inst` = (state == RUN && `pc` < `loaded`) ? mem[`pc`] : 0. The read is asynchronous.
  - Unloaded addresses read as 0. The core treats 0 as a freeze instruction, so a short program halts cleanly.
- `run` = `core_rstn` = 1 exactly when state == RUN. Both are registered, updating on the same edge as the state register.

## Timing
- Reset values:
  - state HDR_LO
  - N, w, `loaded`, `lo` = 0
  - `run` = 0, `core_rstn` = 0
  - `in_ready` = 0 while `rst` is high; `inst` = 0
- `rst` asserted mid-load or mid-run: the load is aborted and all outputs return to their reset values asynchronously.
- Throughput: one byte per cycle; `in_ready` stays high continuously in the load states. A program of N words takes 2 + 2N accepted bytes.
- Last-word write and the RUN entry occur on the same edge. `inst` for mem[N-1] is valid in the first RUN cycle.
- The core is held in reset while `core_rstn` is 0, so its `pc` = 0 on release. Its first clocked instruction is mem[0] at the first edge after `run` rises.
- Gaps in `in_valid` stall the FSM with no state change.

## Test plan
- Reset, then stream 0x03,0x00, 0x11,0xA0, 0x22,0xB0, 0x33,0xC0 with valid held high:
  - `in_ready` is high for 8 cycles then drops.
  - `run` and `core_rstn` rise on the edge accepting 0xC0.
  - `inst` shows 0xA011, 0xB022, 0xC033 for pc 0..2 and 0 for pc = 3.
- Header 0x00,0x00: RUN is entered on the second byte, `loaded` = 0, and `inst` = 0 for every pc.
- Header N = D+2 (0x02,0x01 with PMSB=7), followed by 2(D+2) bytes:
  - All bytes are accepted.
  - mem[0..255] hold the first 256 words; words 256 and 257 are discarded with mem[0] unchanged.
  - RUN is entered after the final byte.
- Random `in_valid` gaps (about 50% duty) during a 4-word load: same final RAM, `loaded`, and RUN edge as the gapless run, with no lost or duplicated bytes.
- Assert `reload` in RUN, and separately mid-body after 1.5 words:
  - The next state is HDR_LO.
  - `run` and `core_rstn` fall on the next edge.
  - A byte offered with `reload` is not accepted.
  - The new 1-word program 0x01,0x00,0x55,0x90 yields `inst` = 0x9055 at pc 0.
- Assert `rst` asynchronously mid-body (between edges): `run`, `core_rstn`, and `in_ready` drop immediately. After release, a fresh header is required.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a length-prefixed byte stream, fills the
// instruction RAM, then releases the core and serves instructions by pc.
module imem_loader #(
    parameter int IMSB = 15,
    parameter int PMSB = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [7:0]      in_data,
    output logic            in_ready,
    input  logic            reload,
    input  logic [PMSB:0]   pc,
    output logic [IMSB:0]   inst,
    output logic            run,
    output logic            core_rstn
);

    localparam int unsigned DEPTH = 1 << (PMSB + 1);

    typedef enum logic [2:0] {
        HDR_LO = 3'd0,
        HDR_HI = 3'd1,
        INS_LO = 3'd2,
        INS_HI = 3'd3,
        RUN    = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     n_q, n_d;
    logic [15:0]     w_q, w_d;
    logic [PMSB+1:0] loaded_q, loaded_d;
    logic [7:0]      lo_q, lo_d;
    logic            run_q, run_d;
    logic            core_rstn_q, core_rstn_d;

    logic [IMSB:0]   mem [DEPTH];
    logic            accept_s;
    logic            mem_we_s;
    logic            w_in_range_s;
    logic [IMSB:0]   mem_wdata_s;

    assign in_ready     = (state_q != RUN) && !reload && !rst;
    assign accept_s     = in_valid && in_ready;
    // Words past the RAM depth are consumed but never written: no wrap.
    assign w_in_range_s = (32'(w_q) < DEPTH);
    assign mem_wdata_s  = (IMSB + 1)'({in_data, lo_q});
    assign run          = run_q;
    assign core_rstn    = core_rstn_q;

    // Next-state and datapath control for the load sequence.
    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        w_d      = w_q;
        loaded_d = loaded_q;
        lo_d     = lo_q;
        mem_we_s = 1'b0;
        if (reload) begin
            state_d  = HDR_LO;
            w_d      = 16'd0;
            loaded_d = {(PMSB + 2){1'b0}};
        end else if (accept_s) begin
            case (state_q)
                HDR_LO: begin
                    n_d[7:0] = in_data;
                    state_d  = HDR_HI;
                end
                HDR_HI: begin
                    n_d[15:8] = in_data;
                    state_d   = ({in_data, n_q[7:0]} == 16'd0) ? RUN : INS_LO;
                end
                INS_LO: begin
                    lo_d    = in_data;
                    state_d = INS_HI;
                end
                INS_HI: begin
                    mem_we_s = w_in_range_s;
                    loaded_d = w_in_range_s ? (loaded_q + {{(PMSB + 1){1'b0}}, 1'b1}) : loaded_q;
                    w_d      = w_q + 16'd1;
                    state_d  = ((w_q + 16'd1) == n_q) ? RUN : INS_LO;
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end else begin
            state_d = state_q;
        end
        run_d       = (state_d == RUN);
        core_rstn_d = (state_d == RUN);
    end

    // Control registers; reset aborts any load and holds the core.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= HDR_LO;
            n_q         <= 16'd0;
            w_q         <= 16'd0;
            loaded_q    <= {(PMSB + 2){1'b0}};
            lo_q        <= 8'd0;
            run_q       <= 1'b0;
            core_rstn_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            w_q         <= w_d;
            loaded_q    <= loaded_d;
            lo_q        <= lo_d;
            run_q       <= run_d;
            core_rstn_q <= core_rstn_d;
        end
    end

    // Instruction RAM write port; contents survive reload and reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[w_q[PMSB:0]] <= mem_wdata_s;
        end
    end

    // Unloaded addresses read as 0 so a short program freezes the core.
    always_comb begin
        inst = {(IMSB + 1){1'b0}};
        if ((state_q == RUN) && ({1'b0, pc} < loaded_q)) begin
            inst = mem[pc];
        end else begin
            inst = {(IMSB + 1){1'b0}};
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected instructions go into a scoreboard
// queue as words are streamed and are compared once the loader is in RUN.
module tb_imem_loader;

    localparam int D = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        reload;
    logic [7:0]  pc;
    logic [15:0] inst;
    logic        run;
    logic        core_rstn;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          addr;
        logic [15:0] val;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] prog[$];
    logic [15:0] model_mem [D];

    imem_loader #(.IMSB(15), .PMSB(7)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .reload    (reload),
        .pc        (pc),
        .inst      (inst),
        .run       (run),
        .core_rstn (core_rstn)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Offer one byte from a falling edge; returns just after the accepting edge.
    task automatic send(input logic [7:0] b, input bit gaps, output int waits);
        waits = 0;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        #1;
        while (!in_ready && waits < 40) begin
            waits++;
            @(negedge clk);
            #1;
        end
        if (waits >= 40) chk("ready_timeout", 32'(waits), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Stream header n plus the first nw words of prog, then queue expectations.
    task automatic load(input int n, input int nw, input bit gaps);
        logic [7:0] bq[$];
        int         w;
        int         stalls;
        int         nl;
        bq.push_back(8'(n));
        bq.push_back(8'(n >> 8));
        for (int i = 0; i < nw; i++) begin
            bq.push_back(prog[i][7:0]);
            bq.push_back(prog[i][15:8]);
        end
        stalls = 0;
        for (int k = 0; k < bq.size(); k++) begin
            send(bq[k], gaps, w);
            stalls += w;
            if (k == bq.size() - 2) chk("run_early", 32'(run), 32'd0);
        end
        chk("load_stalls", 32'(stalls), 32'd0);
        chk("run_rise", 32'(run), 32'd1);
        chk("core_rstn_rise", 32'(core_rstn), 32'd1);
        if (n > 0 && n <= D) begin
            pc = 8'(n - 1);
            #1;
            chk("inst_first_run_cycle", 32'(inst), 32'(prog[n - 1]));
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("ready_in_run", 32'(in_ready), 32'd0);
        nl = (n < D) ? n : D;
        for (int i = 0; i < nl; i++) model_mem[i] = prog[i];
        for (int a = 0; a < D; a++) begin
            exp_t e;
            e.addr = a;
            e.val  = (a < nl) ? model_mem[a] : 16'h0000;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e  = sb.pop_front();
            pc = 8'(e.addr);
            #1;
            chk($sformatf("inst_pc%0d", e.addr), 32'(inst), 32'(e.val));
        end
    endtask

    // Reload with a byte offered alongside; that byte must not be taken.
    task automatic do_reload();
        @(negedge clk);
        reload   = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h01;
        #1;
        chk("ready_during_reload", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("run_after_reload", 32'(run), 32'd0);
        chk("core_rstn_after_reload", 32'(core_rstn), 32'd0);
        @(negedge clk);
        reload   = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("ready_after_reload", 32'(in_ready), 32'd1);
    endtask

    task automatic load_9055();
        prog.delete();
        prog.push_back(16'h9055);
        load(1, 1, 1'b0);
        drain();
    endtask

    initial begin
        int w;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        reload   = 1'b0;
        pc       = 8'h00;

        @(posedge clk);
        #1;
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_run", 32'(run), 32'd0);
        chk("rst_core_rstn", 32'(core_rstn), 32'd0);
        chk("rst_inst", 32'(inst), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 32'(in_ready), 32'd1);

        // Basic three-word program, gapless.
        prog = '{16'hA011, 16'hB022, 16'hC033};
        load(3, 3, 1'b0);
        drain();

        // Reload while running, then a one-word program.
        do_reload();
        load_9055();

        // Empty program: RUN on the second header byte, nothing readable.
        do_reload();
        prog.delete();
        load(0, 0, 1'b0);
        drain();

        // D+2 words: the last two are dropped and do not wrap onto mem[0].
        do_reload();
        prog.delete();
        for (int i = 0; i < D + 2; i++) prog.push_back(16'(i * 16'h0103) ^ 16'h5A00);
        prog[D]     = 16'hDEAD;
        prog[D + 1] = 16'hBEEF;
        load(D + 2, D + 2, 1'b0);
        drain();

        // Four-word load with random valid gaps.
        do_reload();
        prog = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
        load(4, 4, 1'b1);
        drain();

        // Reload mid-body after one and a half words.
        do_reload();
        send(8'h02, 1'b0, w);
        send(8'h00, 1'b0, w);
        send(8'hAA, 1'b0, w);
        send(8'h11, 1'b0, w);
        send(8'hBB, 1'b0, w);
        chk("run_mid_body", 32'(run), 32'd0);
        do_reload();
        load_9055();

        // Asynchronous reset while running.
        @(posedge clk);
        #3;
        pc  = 8'h00;
        rst = 1'b1;
        #1;
        chk("arst_run_run", 32'(run), 32'd0);
        chk("arst_run_core_rstn", 32'(core_rstn), 32'd0);
        chk("arst_run_ready", 32'(in_ready), 32'd0);
        chk("arst_run_inst", 32'(inst), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Asynchronous reset mid-body; afterwards a fresh header is needed.
        send(8'h03, 1'b0, w);
        send(8'h00, 1'b0, w);
        send(8'h34, 1'b0, w);
        send(8'h12, 1'b0, w);
        send(8'h77, 1'b0, w);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_body_ready", 32'(in_ready), 32'd0);
        chk("arst_body_run", 32'(run), 32'd0);
        chk("arst_body_core_rstn", 32'(core_rstn), 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        load_9055();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
